// File: rtl/int_iq_age_selector_pkg.sv
// Shared defaults and types for the integer issue-queue age selector.
package int_iq_age_selector_pkg;

   localparam int unsigned INT_IQ_NUM     = 16;
   localparam int unsigned INT_IQ_W       = $clog2(INT_IQ_NUM);
   localparam int unsigned INT_DISP_W     = 2;
   localparam int unsigned INT_ISSUE_W    = 2;
   localparam int unsigned MD_HOLD_CYCLES = 3;
   localparam int unsigned MD_CNT_W       = 3;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_HOLD  = 2'd1,
      MD_DRAIN = 2'd2
   } md_state_t;

endpackage

// File: rtl/iq_age_oldest_pick.sv
// Combinational oldest-entry pick from an eligibility vector and age matrix.
module iq_age_oldest_pick #(
   parameter int unsigned IQ_NUM = 16,
   parameter int unsigned IQ_W   = $clog2(IQ_NUM)
) (
   input  logic [IQ_NUM-1:0]             elig,
   input  logic [IQ_NUM-1:0][IQ_NUM-1:0] age,
   output logic [IQ_NUM-1:0]             pick_oh,
   output logic [IQ_W-1:0]               pick_idx,
   output logic                          pick_valid
);

   logic [IQ_NUM-1:0] win;

   // An entry wins when no other eligible entry is older; lowest index breaks ties
   always_comb begin
      win = '0;
      for (int i = 0; i < IQ_NUM; i++) begin
         win[i] = elig[i];
         for (int j = 0; j < IQ_NUM; j++) begin
            if (j != i && elig[j] && age[j][i]) win[i] = 1'b0;
         end
      end
   end

   assign pick_oh    = win & (~win + IQ_NUM'(1));
   assign pick_valid = |win;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < IQ_NUM; i++) begin
         if (pick_oh[i]) pick_idx = IQ_W'(i);
      end
   end

endmodule

// File: rtl/int_iq_age_selector.sv
// Integer IQ issue selector: age-matrix oldest-first grants plus mul/div throttle FSM.
module int_iq_age_selector
   import int_iq_age_selector_pkg::md_state_t,
          int_iq_age_selector_pkg::MD_IDLE,
          int_iq_age_selector_pkg::MD_DRAIN;
#(
   parameter int unsigned IQ_NUM  = int_iq_age_selector_pkg::INT_IQ_NUM,
   parameter int unsigned IQ_W    = $clog2(IQ_NUM),
   parameter int unsigned DISP_W  = int_iq_age_selector_pkg::INT_DISP_W,
   parameter int unsigned ISSUE_W = int_iq_age_selector_pkg::INT_ISSUE_W,
   parameter int unsigned MD_HOLD = int_iq_age_selector_pkg::MD_HOLD_CYCLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [IQ_NUM-1:0]               entry_valid,
   input  logic [IQ_NUM-1:0]               entry_ready,
   input  logic [IQ_NUM-1:0]               entry_is_ctrl,
   input  logic [IQ_NUM-1:0]               entry_is_muldiv,
   input  logic [DISP_W-1:0]               disp_valid,
   input  logic [DISP_W-1:0][IQ_W-1:0]     disp_idx,
   input  logic                            issue_lock,
   input  logic                            muldiv_busy,
   input  logic                            recovery_flush,
   output logic [ISSUE_W-1:0]              issue_valid,
   output logic [ISSUE_W-1:0][IQ_W-1:0]    issue_idx,
   output logic [1:0]                      md_state
);

   localparam int unsigned CNT_W = int_iq_age_selector_pkg::MD_CNT_W;

   logic [IQ_NUM-1:0][IQ_NUM-1:0] age_q, age_nxt;
   md_state_t                     state_q, state_nxt;
   logic [CNT_W-1:0]              cnt_q, cnt_nxt;

   logic              md_issuable, md_grant;
   logic [IQ_NUM-1:0] elig_alu, elig_ctl, elig_md, elig_p0;

   logic [IQ_NUM-1:0] pick_elig [ISSUE_W];
   logic [IQ_NUM-1:0] taken     [ISSUE_W];
   logic [IQ_NUM-1:0] pick_oh   [ISSUE_W];
   logic [IQ_W-1:0]   pick_idx  [ISSUE_W];
   logic              pick_v    [ISSUE_W];

   logic [IQ_NUM-1:0] md_oh;
   logic [IQ_W-1:0]   md_idx;
   logic              md_v;

   logic              sel_v;
   logic [IQ_NUM-1:0] sel_oh;
   logic [IQ_W-1:0]   sel_idx;
   logic [IQ_NUM-1:0] grant_mask;
   logic              grant_dup;
   logic              disp_dup;

   // Lanes applied in order, so a later lane ends up younger than an earlier one
   always_comb begin
      age_nxt = age_q;
      for (int k = 0; k < DISP_W; k++) begin
         if (disp_valid[k]) begin
            age_nxt[disp_idx[k]] = '0;
            for (int i = 0; i < IQ_NUM; i++) begin
               if (IQ_W'(i) != disp_idx[k]) age_nxt[i][disp_idx[k]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_q   <= '0;
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         age_q   <= age_nxt;
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign md_issuable = (state_q == MD_IDLE) && !muldiv_busy;
   assign elig_alu    = entry_valid & entry_ready & ~entry_is_ctrl & ~entry_is_muldiv;
   assign elig_ctl    = entry_valid & entry_ready & entry_is_ctrl;
   assign elig_md     = entry_valid & entry_ready & entry_is_muldiv & {IQ_NUM{md_issuable}};
   assign elig_p0     = (|elig_ctl) ? elig_ctl : elig_alu;

   // Port 0 takes ctrl-or-ALU; later ports chain ALU picks past earlier grants
   for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
      if (p == 0) begin : g_first
         assign taken[p]     = '0;
         assign pick_elig[p] = elig_p0;
      end else begin : g_next
         assign taken[p]     = taken[p-1] | pick_oh[p-1];
         assign pick_elig[p] = elig_alu & ~taken[p];
      end

      iq_age_oldest_pick #(
         .IQ_NUM (IQ_NUM),
         .IQ_W   (IQ_W)
      ) u_pick (
         .elig       (pick_elig[p]),
         .age        (age_q),
         .pick_oh    (pick_oh[p]),
         .pick_idx   (pick_idx[p]),
         .pick_valid (pick_v[p])
      );
   end

   iq_age_oldest_pick #(
      .IQ_NUM (IQ_NUM),
      .IQ_W   (IQ_W)
   ) u_pick_md (
      .elig       (elig_md & ~pick_oh[0]),
      .age        (age_q),
      .pick_oh    (md_oh),
      .pick_idx   (md_idx),
      .pick_valid (md_v)
   );

   // Port assembly and gating; the last port prefers mul/div over ALU
   always_comb begin
      issue_valid = '0;
      issue_idx   = '0;
      md_grant    = 1'b0;
      sel_v       = 1'b0;
      sel_oh      = '0;
      sel_idx     = '0;
      grant_mask  = '0;
      grant_dup   = 1'b0;
      if (!rst && !issue_lock && !recovery_flush) begin
         for (int p = 0; p < ISSUE_W; p++) begin
            if (p == ISSUE_W - 1 && md_v) begin
               sel_v    = 1'b1;
               sel_oh   = md_oh;
               sel_idx  = md_idx;
               md_grant = 1'b1;
            end else begin
               sel_v   = pick_v[p];
               sel_oh  = pick_oh[p];
               sel_idx = pick_idx[p];
            end
            if (sel_v) begin
               if (|(grant_mask & sel_oh)) grant_dup = 1'b1;
               grant_mask     = grant_mask | sel_oh;
               issue_valid[p] = 1'b1;
               issue_idx[p]   = sel_idx;
            end
         end
      end
   end

   // Mul/div throttle: hold off after each grant, then wait for the unit to free up
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         MD_IDLE: begin
            if (md_grant) begin
               state_nxt = int_iq_age_selector_pkg::MD_HOLD;
               cnt_nxt   = CNT_W'(1);
            end
         end
         int_iq_age_selector_pkg::MD_HOLD: begin
            if (!recovery_flush) begin
               cnt_nxt = cnt_q + CNT_W'(1);
               if (cnt_nxt >= CNT_W'(MD_HOLD)) state_nxt = MD_DRAIN;
            end
         end
         MD_DRAIN: begin
            if (!muldiv_busy) begin
               state_nxt = MD_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = MD_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign md_state = state_q;

   always_comb begin
      disp_dup = 1'b0;
      for (int a = 0; a < DISP_W; a++) begin
         for (int b = a + 1; b < DISP_W; b++) begin
            if (disp_valid[a] && disp_valid[b] && disp_idx[a] == disp_idx[b]) disp_dup = 1'b1;
         end
      end
   end

   a_no_dup_disp:  assert property (@(posedge clk) disable iff (rst) !disp_dup);
   a_no_dup_grant: assert property (@(posedge clk) disable iff (rst) !grant_dup);

endmodule

// File: tb/tb_int_iq_age_selector.sv
// Directed bench for int_iq_age_selector with hand-computed grants and FSM states.
module tb_int_iq_age_selector;

   localparam int unsigned IQ_NUM  = 16;
   localparam int unsigned IQ_W    = 4;
   localparam int unsigned DISP_W  = 2;
   localparam int unsigned ISSUE_W = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [IQ_NUM-1:0]            ev, er, ec, em;
   logic [DISP_W-1:0]            dv;
   logic [DISP_W-1:0][IQ_W-1:0]  di;
   logic                         lock, busy, flush;
   logic [ISSUE_W-1:0]           issue_valid;
   logic [ISSUE_W-1:0][IQ_W-1:0] issue_idx;
   logic [1:0]                   md_state;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   always #5 clk = ~clk;

   int_iq_age_selector #(
      .IQ_NUM  (IQ_NUM),
      .IQ_W    (IQ_W),
      .DISP_W  (DISP_W),
      .ISSUE_W (ISSUE_W),
      .MD_HOLD (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .entry_valid     (ev),
      .entry_ready     (er),
      .entry_is_ctrl   (ec),
      .entry_is_muldiv (em),
      .disp_valid      (dv),
      .disp_idx        (di),
      .issue_lock      (lock),
      .muldiv_busy     (busy),
      .recovery_flush  (flush),
      .issue_valid     (issue_valid),
      .issue_idx       (issue_idx),
      .md_state        (md_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic grant(input string tag, input logic [1:0] v, input int i0, input int i1);
      chk({tag, "_valid"}, 32'(issue_valid), 32'(v));
      if (v[0]) chk({tag, "_p0"}, 32'(issue_idx[0]), 32'(i0));
      if (v[1]) chk({tag, "_p1"}, 32'(issue_idx[1]), 32'(i1));
   endtask

   initial begin
      rst = 1'b1; ev = '0; er = '0; ec = '0; em = '0; dv = '0; di = '0;
      lock = 1'b0; busy = 1'b0; flush = 1'b0;
      #1;
      chk("por_valid", 32'(issue_valid), 32'd0);
      chk("por_state", 32'(md_state), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: async reset mid-operation, then lane-ordered dispatch of 0/1
      ev = 16'h000F; er = 16'h000F;
      #2; rst = 1'b1; #1;
      chk("t1_rst_valid", 32'(issue_valid), 32'd0);
      chk("t1_rst_idx0", 32'(issue_idx[0]), 32'd0);
      chk("t1_rst_idx1", 32'(issue_idx[1]), 32'd0);
      chk("t1_rst_state", 32'(md_state), 32'd0);
      @(negedge clk);
      rst = 1'b0; ev = '0; er = '0;
      dv = 2'b11; di[0] = 4'd0; di[1] = 4'd1;
      @(negedge clk);
      dv = '0; ev[0] = 1'b1; er[0] = 1'b1; ev[1] = 1'b1; er[1] = 1'b1; #1;
      grant("t1_pair", 2'b11, 0, 1);
      @(negedge clk);
      ev = '0; er = '0;

      // 2: separate-cycle dispatch 7, 3, 12
      dv = 2'b01; di[0] = 4'd7;
      @(negedge clk);
      di[0] = 4'd3; ev[7] = 1'b1; er[7] = 1'b1;
      @(negedge clk);
      di[0] = 4'd12; ev[3] = 1'b1; er[3] = 1'b1;
      @(negedge clk);
      dv = '0; ev[12] = 1'b1; er[12] = 1'b1; #1;
      grant("t2_pair", 2'b11, 7, 3);
      @(negedge clk);
      ev[7] = 1'b0; er[7] = 1'b0; ev[3] = 1'b0; er[3] = 1'b0; #1;
      grant("t2_next", 2'b01, 12, 0);
      @(negedge clk);
      ev = '0; er = '0;

      // 3: older ctrl 9, same-cycle lanes 5 then 2
      dv = 2'b01; di[0] = 4'd9;
      @(negedge clk);
      ev[9] = 1'b1; er[9] = 1'b1; ec[9] = 1'b1;
      dv = 2'b11; di[0] = 4'd5; di[1] = 4'd2; #1;
      grant("t3_ctrl_only", 2'b01, 9, 0);
      @(negedge clk);
      dv = '0; ev[5] = 1'b1; er[5] = 1'b1; ev[2] = 1'b1; er[2] = 1'b1; #1;
      grant("t3_ctrl_alu", 2'b11, 9, 5);
      ec[5] = 1'b1; ec[2] = 1'b1; #1;
      grant("t3_all_ctrl", 2'b01, 9, 0);
      ev = '0; #1;
      grant("t3_empty", 2'b00, 0, 0);
      @(negedge clk);
      er = '0; ec = '0;

      // 4: mul/div grant and throttle
      dv = 2'b11; di[0] = 4'd4; di[1] = 4'd6;
      @(negedge clk);
      dv = '0; ev[4] = 1'b1; er[4] = 1'b1; em[4] = 1'b1; #1;
      grant("t4_md", 2'b10, 0, 4);
      chk("t4_idle", 32'(md_state), 32'd0);
      @(negedge clk);
      ev[4] = 1'b0; er[4] = 1'b0; em[4] = 1'b0;
      ev[6] = 1'b1; er[6] = 1'b1; em[6] = 1'b1; #1;
      chk("t4_hold1", 32'(md_state), 32'd1);
      grant("t4_blk1", 2'b00, 0, 0);
      @(negedge clk); #1;
      chk("t4_hold2", 32'(md_state), 32'd1);
      grant("t4_blk2", 2'b00, 0, 0);
      @(negedge clk);
      busy = 1'b1; #1;
      chk("t4_drain", 32'(md_state), 32'd2);
      grant("t4_blk3", 2'b00, 0, 0);
      for (int n = 0; n < 2; n++) begin
         @(negedge clk); #1;
         chk("t4_drain_busy", 32'(md_state), 32'd2);
         grant("t4_blk_busy", 2'b00, 0, 0);
      end
      @(negedge clk);
      busy = 1'b0; #1;
      chk("t4_drain_last", 32'(md_state), 32'd2);
      grant("t4_blk_last", 2'b00, 0, 0);
      @(negedge clk); #1;
      chk("t4_reidle", 32'(md_state), 32'd0);
      grant("t4_md2", 2'b10, 0, 6);

      // 5: flush during hold with count 2 freezes the counter
      @(negedge clk);
      ev[6] = 1'b0; er[6] = 1'b0; em[6] = 1'b0; #1;
      chk("t5_hold_c1", 32'(md_state), 32'd1);
      @(negedge clk);
      flush = 1'b1; ev[10] = 1'b1; er[10] = 1'b1; #1;
      chk("t5_hold_c2", 32'(md_state), 32'd1);
      grant("t5_flush", 2'b00, 0, 0);
      @(negedge clk);
      flush = 1'b0; #1;
      chk("t5_frozen", 32'(md_state), 32'd1);
      grant("t5_alu", 2'b01, 10, 0);
      @(negedge clk); #1;
      chk("t5_drain", 32'(md_state), 32'd2);
      @(negedge clk); #1;
      chk("t5_idle", 32'(md_state), 32'd0);

      // 6: issue_lock suppresses ctrl, ALU and mul/div
      ev[9] = 1'b1; er[9] = 1'b1; ec[9] = 1'b1;
      ev[6] = 1'b1; er[6] = 1'b1; em[6] = 1'b1;
      lock = 1'b1; #1;
      grant("t6_lock", 2'b00, 0, 0);
      @(negedge clk); #1;
      chk("t6_state", 32'(md_state), 32'd0);
      grant("t6_lock2", 2'b00, 0, 0);
      lock = 1'b0; #1;
      grant("t6_unlock", 2'b11, 9, 6);
      @(negedge clk); #1;
      chk("t6_hold", 32'(md_state), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/int_iq_age_selector.md
Name: int_iq_age_selector

Overview:
- Parametrised issue selector for the integer issue queue: picks up to ISSUE_W ready entries per cycle by true relative age.
- Oldest-first order comes from an IQ_NUM x IQ_NUM age matrix, not saturating counters, so age never aliases.
- Sits between the int issue queue slot array and the int register-read stage.
- Owns the mul/div issue throttle state machine.

Parameters:
IQ_NUM, 16, issue queue entries (power of 2, 4..32)
IQ_W, $clog2(IQ_NUM), slot index width
DISP_W, 2, dispatch lanes per cycle (1..4)
ISSUE_W, 2, issue ports (2..4)
MD_HOLD, 3, minimum cycles between mul/div issues (1..7)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
entry_valid  in  [IQ_NUM]  slot occupied
entry_ready  in  [IQ_NUM]  operands ready
entry_is_ctrl  in  [IQ_NUM]  branch/jump or CSR
entry_is_muldiv  in  [IQ_NUM]  mul/div op
disp_valid  in  [DISP_W]  dispatch lane writes a slot this cycle
disp_idx  in  [DISP_W] x IQ_W  slot written by each lane
issue_lock  in  1  suppress all grants
muldiv_busy  in  1  mul/div unit cannot accept
recovery_flush  in  1  pipeline flush this cycle
issue_valid  out  [ISSUE_W]  grant valid per port
issue_idx  out  [ISSUE_W] x IQ_W  granted slot per port
md_state  out  2  throttle state, debug/perf

Behaviour:
- Single clock domain. Only the age matrix and the throttle FSM are registered; grants are combinational from current-cycle inputs (0-cycle latency).
- Asynchronous reset:
  - Age matrix is cleared to all 0, FSM goes to MD_IDLE, hold counter is 0.
  - While rst is high: all issue_valid = 0 and issue_idx = 0.
- Age matrix semantics: age[i][j] = 1 means i is older than j. The diagonal is ignored.
- Age matrix update on each clk edge, for every lane k with disp_valid[k]:
  - Row disp_idx[k] is set to 0 (the new entry is younger than every existing entry).
  - Column disp_idx[k] is set to 1 for all other rows.
  - Between same-cycle lanes, lane a < b makes a older: age[disp_idx[a]][disp_idx[b]] = 1, age[disp_idx[b]][disp_idx[a]] = 0.
  - Duplicate disp_idx among valid lanes is illegal and assertion-checked.
- Eligibility:
  - elig_alu[i] = valid & ready & ~ctrl & ~muldiv
  - elig_ctl[i] = valid & ready & ctrl
  - elig_md[i] = valid & ready & muldiv & md_issuable
- Oldest pick within a class: i wins if elig[i] and no eligible j has age[j][i] = 1. Exactly one winner when the set is non-empty.
- Port allocation:
  - Port 0: oldest ctrl if any, else oldest ALU.
  - Port ISSUE_W-1: oldest mul/div if md_issuable and one exists.
  - All remaining ports: successive oldest ALU entries, each excluding entries already granted. The last port falls back to ALU when no mul/div is granted.
  - No slot is granted twice. Unfilled ports have issue_valid = 0.
- Gating:
  - issue_lock = 1 forces every issue_valid to 0.
  - recovery_flush = 1 also forces every issue_valid to 0 (new behaviour).
- Throttle FSM, states MD_IDLE = 0, MD_HOLD = 1, MD_DRAIN = 2:
  - md_issuable = (state == MD_IDLE) & ~muldiv_busy.
  - MD_IDLE -> MD_HOLD when a mul/div grant is issued (valid, unlocked, unflushed); hold counter loads 1.
  - MD_HOLD: counter increments each cycle. When it reaches MD_HOLD, go to MD_DRAIN. A recovery_flush freezes the counter for that cycle.
  - MD_DRAIN -> MD_IDLE on the first cycle with ~muldiv_busy; otherwise stay.
- Boundaries:
  - An entry dispatched in the same cycle it is granted is a legal overlap only if the IQ deallocates it. Its matrix row/column is still rewritten.
  - An empty IQ produces no grants.
  - All-ctrl entries: only port 0 issues.

Decomposition:
- Falco_pkg gains INT_IQ_NUM-based defaults, the md_state_t enum (MD_IDLE/MD_HOLD/MD_DRAIN) and the MD_HOLD constant.
- One sub-module, iq_age_oldest_pick: combinational, takes the eligibility vector and the age matrix, outputs one-hot/index/valid. Instantiated ISSUE_W+1 times, with masks chained for successive ALU picks.

Test Plan:
1. Reset mid-operation: assert rst with 4 valid ready ALU entries -> issue_valid = 0 immediately (asynchronously) and md_state = 0; after release, slots 0/1 dispatched in lanes 0/1 -> issue_idx = {0,1}.
2. Dispatch slot 7, then 3, then 12 in separate cycles, all ALU and ready -> port0 = 7, port1 = 3; slot 12 issues the next cycle once 7 and 3 are invalidated.
3. Same-cycle dispatch lane0 = 5, lane1 = 2, plus ready ctrl slot 9 (older) -> port0 = 9, port1 = 5.
4. Ready mul/div slot 4 with muldiv_busy = 0 -> port1 = 4 and FSM goes to MD_HOLD; a second ready mul/div is blocked for 3 cycles; with muldiv_busy = 1 it stays blocked in MD_DRAIN until busy drops.
5. recovery_flush = 1 during MD_HOLD with count 2 -> all issue_valid = 0 and the count stays at 2 the next cycle.
6. issue_lock = 1 with ready ctrl + ALU + mul/div -> no grants and md_state stays MD_IDLE.
